// File: rtl/seq_detect_param.sv
// Serial pattern detector with a runtime-loadable pattern of 1..PAT_W bits.
// Produces a registered one-cycle match pulse and a saturating match counter.
module seq_detect_param #(
    parameter int PAT_W = 8,
    parameter int LEN_W = 5,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [PAT_W-1:0] pattern,
    input  logic [LEN_W-1:0] pat_len,
    input  logic             overlap,
    input  logic             en,
    input  logic             a,
    output logic             y,
    output logic [CNT_W-1:0] match_cnt,
    output logic             cnt_sat,
    output logic             cfg_err,
    output logic             armed
);

    localparam logic [LEN_W-1:0] PAT_W_L = LEN_W'(PAT_W);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state;
    logic [PAT_W-1:0] pat_q;
    logic [LEN_W-1:0] len_q;
    logic             ovl_q;
    logic [PAT_W-1:0] hist;
    logic [LEN_W-1:0] fill;

    logic [PAT_W-1:0] cand;
    logic [PAT_W-1:0] mask;
    logic [LEN_W-1:0] fill_nxt;
    logic             len_ok;
    logic             hit;

    assign armed = (state == RUN);

    // Candidate window includes the bit being sampled now; only the low
    // len_q bits take part in the comparison.
    always_comb begin
        cand     = {hist[PAT_W-2:0], a};
        mask     = '0;
        for (int i = 0; i < PAT_W; i++) begin
            mask[i] = (LEN_W'(i) < len_q);
        end
        fill_nxt = (fill == PAT_W_L) ? fill : fill + LEN_W'(1);
        len_ok   = (pat_len != '0) && (pat_len <= PAT_W_L);
        hit      = (fill_nxt >= len_q) && (((cand ^ pat_q) & mask) == '0);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            pat_q     <= '0;
            len_q     <= '0;
            ovl_q     <= 1'b0;
            hist      <= '0;
            fill      <= '0;
            y         <= 1'b0;
            match_cnt <= '0;
            cnt_sat   <= 1'b0;
            cfg_err   <= 1'b0;
        end else if (load) begin
            hist      <= '0;
            fill      <= '0;
            y         <= 1'b0;
            match_cnt <= '0;
            cnt_sat   <= 1'b0;
            if (len_ok) begin
                pat_q   <= pattern;
                len_q   <= pat_len;
                ovl_q   <= overlap;
                cfg_err <= 1'b0;
                state   <= RUN;
            end else begin
                cfg_err <= 1'b1;
                state   <= IDLE;
            end
        end else begin
            case (state)
                IDLE: begin
                    y <= 1'b0;
                end
                RUN: begin
                    if (!en) begin
                        y <= 1'b0;
                    end else begin
                        hist <= cand;
                        if (hit) begin
                            y    <= 1'b1;
                            // Non-overlapping mode demands a full fresh pattern.
                            fill <= ovl_q ? fill_nxt : '0;
                            if (match_cnt != CNT_MAX) begin
                                match_cnt <= match_cnt + CNT_W'(1);
                                if (match_cnt == CNT_MAX - CNT_W'(1)) begin
                                    cnt_sat <= 1'b1;
                                end
                            end
                        end else begin
                            y    <= 1'b0;
                            fill <= fill_nxt;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    y     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_detect_param.sv
// Directed and randomized bench for seq_detect_param against a queue-based
// model of the bit stream seen since the last load or non-overlapping match.
module tb_seq_detect_param;

    localparam int PAT_W = 8;
    localparam int LEN_W = 5;
    localparam int CNT_W = 8;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             load = 1'b0;
    logic [PAT_W-1:0] pattern = '0;
    logic [LEN_W-1:0] pat_len = '0;
    logic             overlap = 1'b0;
    logic             en = 1'b0;
    logic             a = 1'b0;
    logic             y;
    logic [CNT_W-1:0] match_cnt;
    logic             cnt_sat;
    logic             cfg_err;
    logic             armed;

    seq_detect_param #(.PAT_W(PAT_W), .LEN_W(LEN_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .load(load), .pattern(pattern), .pat_len(pat_len),
        .overlap(overlap), .en(en), .a(a), .y(y), .match_cnt(match_cnt),
        .cnt_sat(cnt_sat), .cfg_err(cfg_err), .armed(armed)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;

    // Reference model state
    bit m_armed, m_err, m_y, m_sat, m_ovl;
    int m_cnt, m_len;
    bit [PAT_W-1:0] m_pat;
    bit q[$];
    int npulse;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_armed = 0; m_err = 0; m_y = 0; m_sat = 0; m_ovl = 0;
        m_cnt = 0; m_len = 0; m_pat = '0;
        q.delete();
    endtask

    function automatic bit tail_matches();
        if (q.size() < m_len) return 0;
        for (int k = 0; k < m_len; k++) begin
            if (q[q.size() - m_len + k] != m_pat[m_len - 1 - k]) return 0;
        end
        return 1;
    endfunction

    task automatic model_step(input bit ld, input bit [PAT_W-1:0] p, input int l,
                              input bit ov, input bit e, input bit b);
        if (ld) begin
            m_y = 0; m_cnt = 0; m_sat = 0;
            q.delete();
            if (l >= 1 && l <= PAT_W) begin
                m_armed = 1; m_err = 0; m_pat = p; m_len = l; m_ovl = ov;
            end else begin
                m_armed = 0; m_err = 1;
            end
        end else if (!m_armed || !e) begin
            m_y = 0;
        end else begin
            q.push_back(b);
            if (q.size() > 4 * PAT_W) void'(q.pop_front());
            m_y = tail_matches();
            if (m_y) begin
                if (m_cnt < CMAX) begin
                    m_cnt++;
                    if (m_cnt == CMAX) m_sat = 1;
                end
                if (!m_ovl) q.delete();
            end
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".y"},       32'(y),         32'(m_y));
        chk({tag, ".cnt"},     32'(match_cnt), 32'(m_cnt));
        chk({tag, ".sat"},     32'(cnt_sat),   32'(m_sat));
        chk({tag, ".cfg_err"}, 32'(cfg_err),   32'(m_err));
        chk({tag, ".armed"},   32'(armed),     32'(m_armed));
    endtask

    task automatic tick(input string tag, input bit ld, input bit [PAT_W-1:0] p,
                        input int l, input bit ov, input bit e, input bit b);
        load = ld; pattern = p; pat_len = LEN_W'(l); overlap = ov; en = e; a = b;
        model_step(ld, p, l, ov, e, b);
        @(posedge clk);
        #1;
        if (y === 1'b1) npulse++;
        check_all(tag);
        load = 0; en = 0;
    endtask

    task automatic bits(input string tag, input bit e, input bit b);
        tick(tag, 0, '0, 0, 0, e, b);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        rst = 1'b1;

        // Idle before any load: en/a ignored
        bits("idle_en", 1, 1);
        bits("idle_en2", 1, 0);

        // Invalid loads then a valid one
        tick("ld_len0", 1, 8'h05, 0, 1, 0, 0);
        bits("err_run", 1, 1);
        tick("ld_len9", 1, 8'h05, PAT_W + 1, 1, 0, 0);
        bits("err_run2", 1, 1);
        tick("ld_valid", 1, 8'h05, 3, 1, 0, 0);

        // 101 overlapping on 1,0,1,0,1
        npulse = 0;
        tick("ov_ld", 1, 8'h05, 3, 1, 0, 0);
        foreach (q[i]) ;
        bits("ov_b1", 1, 1); bits("ov_b2", 1, 0); bits("ov_b3", 1, 1);
        bits("ov_b4", 1, 0); bits("ov_b5", 1, 1); bits("ov_tail", 0, 0);
        chk("ov_total_cnt", 32'(match_cnt), 32'd2);
        chk("ov_pulses", 32'(npulse), 32'd2);

        // Same stream, non-overlapping
        npulse = 0;
        tick("no_ld", 1, 8'h05, 3, 0, 0, 0);
        bits("no_b1", 1, 1); bits("no_b2", 1, 0); bits("no_b3", 1, 1);
        bits("no_b4", 1, 0); bits("no_b5", 1, 1); bits("no_tail", 0, 0);
        chk("no_total_cnt", 32'(match_cnt), 32'd1);
        chk("no_pulses", 32'(npulse), 32'd1);

        // Gaps in en are transparent
        npulse = 0;
        tick("gap_ld", 1, 8'h05, 3, 1, 0, 0);
        bits("gap_b1", 1, 1);
        bits("gap_i1", 0, 1); bits("gap_i2", 0, 0); bits("gap_i3", 0, 1);
        bits("gap_b2", 1, 0); bits("gap_b3", 1, 1); bits("gap_tail", 0, 0);
        chk("gap_pulses", 32'(npulse), 32'd1);

        // Asynchronous reset mid-stream discards partial match
        tick("rs_ld", 1, 8'h05, 3, 1, 0, 0);
        bits("rs_b1", 1, 1); bits("rs_b2", 1, 0);
        #2 rst = 1'b0;
        #1;
        model_reset();
        check_all("rs_async");
        @(posedge clk);
        #1;
        check_all("rs_held");
        rst = 1'b1;
        tick("rs_reld", 1, 8'h05, 3, 1, 0, 0);
        bits("rs_b3", 1, 1);
        chk("rs_no_y", 32'(y), 32'd0);

        // Load wins over en in the same cycle
        tick("prio_ld", 1, 8'h01, 1, 1, 1, 1);
        bits("prio_next", 0, 0);

        // Counter saturation with single-bit pattern
        npulse = 0;
        tick("sat_ld", 1, 8'h01, 1, 1, 0, 0);
        for (int i = 0; i < 300; i++) bits("sat_run", 1, 1);
        bits("sat_tail", 0, 0);
        chk("sat_pulses", 32'(npulse), 32'd300);
        chk("sat_cnt", 32'(match_cnt), 32'd255);
        chk("sat_flag", 32'(cnt_sat), 32'd1);

        // Randomized configurations and streams
        for (int r = 0; r < 12; r++) begin
            int l;
            l = $urandom_range(1, PAT_W);
            tick("rnd_ld", 1, PAT_W'($urandom), l, 1'($urandom), 1'($urandom), 1'($urandom));
            for (int i = 0; i < 60; i++) begin
                if ($urandom_range(0, 99) < 2)
                    tick("rnd_bad", 1, PAT_W'($urandom),
                         ($urandom_range(0, 1) != 0) ? 0 : $urandom_range(PAT_W + 1, 31),
                         1'($urandom), 1'($urandom), 1'($urandom));
                else
                    bits("rnd", ($urandom_range(0, 3) != 0), 1'($urandom));
            end
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
